// File: rtl/softmax_row_sequencer.sv
// Row-level sequencer for the 32-element softmax output path: drives the core and row-flatten writer per row.
// Define SOFTMAX_SEQ_TIMEOUT_EN to add a watchdog on the SM_WAIT and FL_RUN states.
module softmax_row_sequencer #(
  parameter int NUM_ROWS    = 32,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int RW         = $clog2(NUM_ROWS),
  localparam int ADDR_W     = RW + 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [RW:0]       i_num_rows,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [RW-1:0]     o_row_idx,
  output logic              o_sm_start,
  output logic [RW-1:0]     o_sm_row,
  input  logic              i_sm_done,
  output logic              o_fl_clr,
  output logic              o_fl_valid,
  input  logic              i_fl_done,
  input  logic              i_fl_wr_en,
  input  logic [4:0]        i_fl_wr_addr,
  input  logic [DATA_W-1:0] i_fl_wr_data,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_wr_addr,
  output logic [DATA_W-1:0] o_mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SM_START, S_SM_WAIT, S_FL_RUN, S_FL_CHK, S_DONE
  } state_t;

  localparam logic [RW:0] NUM_ROWS_W = (RW + 1)'(NUM_ROWS);
  localparam logic [RW:0] ONE_W      = (RW + 1)'(1);
  localparam logic [5:0]  ROW_WRITES = 6'd32;
  localparam logic [5:0]  WR_CNT_MAX = 6'd63;

  state_t          state_reg, state_next;
  logic [RW-1:0]   row_reg, last_reg;
  logic [5:0]      wr_cnt_reg;
  logic            err_reg;
  logic            busy_next, done_next, fl_clr_next, sm_start_next, fl_valid_next;
  logic            start_ok, is_last, relay_ok, err_set, timeout;
  logic [RW:0]     num_clamped;

  assign start_ok    = (state_reg == S_IDLE) && i_start;
  assign is_last     = (row_reg == last_reg);
  assign relay_ok    = i_fl_wr_en && ((state_reg == S_FL_RUN) || (state_reg == S_FL_CHK));
  assign num_clamped = (i_num_rows > NUM_ROWS_W) ? NUM_ROWS_W : i_num_rows;

  // A row is bad if the writer did not produce exactly 32 writes, or wrote outside its window
  assign err_set = ((state_reg == S_FL_CHK) && (wr_cnt_reg != ROW_WRITES)) ||
                   (i_fl_wr_en && !relay_ok) || timeout;

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_reg;
  logic            wd_state;

  assign wd_state = (state_reg == S_SM_WAIT) || (state_reg == S_FL_RUN);
  assign timeout  = wd_state && (wd_reg == WD_LAST);

  // Restarts on every state change so SM_WAIT and FL_RUN each get a full budget
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_reg <= '0;
    end else if (state_next != state_reg) begin
      wd_reg <= '0;
    end else if (wd_state && !timeout) begin
      wd_reg <= wd_reg + WD_W'(1);
    end
  end
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          state_next = (i_num_rows == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR:      state_next = S_SM_START;
      S_SM_START: state_next = S_SM_WAIT;
      S_SM_WAIT: begin
        if (timeout) begin
          state_next = S_DONE;
        end else if (i_sm_done) begin
          state_next = S_FL_RUN;
        end
      end
      S_FL_RUN: begin
        if (timeout) begin
          state_next = S_DONE;
        end else if (i_fl_done) begin
          state_next = S_FL_CHK;
        end
      end
      S_FL_CHK:   state_next = is_last ? S_DONE : S_CLR;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they register in step with it
  always_comb begin
    busy_next     = (state_next != S_IDLE);
    done_next     = (state_next == S_DONE);
    fl_clr_next   = (state_next == S_CLR);
    sm_start_next = (state_next == S_SM_START);
    fl_valid_next = (state_next == S_FL_RUN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_fl_clr      <= 1'b0;
      o_sm_start    <= 1'b0;
      o_fl_valid    <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
      row_reg       <= '0;
      last_reg      <= '0;
      wr_cnt_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      o_busy      <= busy_next;
      o_done      <= done_next;
      o_fl_clr    <= fl_clr_next;
      o_sm_start  <= sm_start_next;
      o_fl_valid  <= fl_valid_next;
      o_mem_wr_en <= relay_ok;
      if (relay_ok) begin
        o_mem_wr_addr <= {row_reg, i_fl_wr_addr};
        o_mem_wr_data <= i_fl_wr_data;
      end

      if (start_ok) begin
        row_reg  <= '0;
        last_reg <= RW'(num_clamped - ONE_W);
      end else if ((state_reg == S_FL_CHK) && !is_last) begin
        row_reg <= row_reg + RW'(1);
      end

      if (state_reg == S_CLR) begin
        wr_cnt_reg <= '0;
      end else if (relay_ok && (wr_cnt_reg != WR_CNT_MAX)) begin
        wr_cnt_reg <= wr_cnt_reg + 6'd1;
      end

      if (err_set) begin
        err_reg <= 1'b1;
      end else if (start_ok) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign o_err     = err_reg;
  assign o_row_idx = row_reg;
  assign o_sm_row  = row_reg;

endmodule

// File: doc/softmax_row_sequencer.md
# softmax_row_sequencer

Row-level controller for the 32-element softmax output path. It runs a programmed number of rows through the softmax core and the row-flatten writer, one row at a time. Between rows it clears the writer's sticky done state. It relocates the writer's 5-bit local write address into a global output-buffer address and checks that every row produces exactly 32 writes.

## Interface
Parameters:
- NUM_ROWS, 32: maximum rows per job; power of two.
- DATA_W, 16: element width.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with SOFTMAX_SEQ_TIMEOUT_EN.

Derived: RW = $clog2(NUM_ROWS); ADDR_W = RW+5.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_num_rows  in  RW+1  row count, sampled with i_start.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle job-complete pulse.
- o_err  out  1  sticky error flag; cleared by i_start accepted in IDLE.
- o_row_idx  out  RW  current row.
- o_sm_start  out  1  one-cycle pulse to the softmax core.
- o_sm_row  out  RW  row index for the core; equals o_row_idx.
- i_sm_done  in  1  core pulse: row result is on the writer's matrix input.
- o_fl_clr  out  1  one-cycle clear; top level ORs it into the writer's reset.
- o_fl_valid  out  1  writer start level.
- i_fl_done  in  1  writer done, sticky until cleared.
- i_fl_wr_en  in  1  writer write strobe.
- i_fl_wr_addr  in  5  writer local address.
- i_fl_wr_data  in  DATA_W  writer data.
- o_mem_wr_en  out  1  output-buffer write enable.
- o_mem_wr_addr  out  ADDR_W  equals {row, local addr}.
- o_mem_wr_data  out  DATA_W  write data.

## Operation
All outputs are registered. Reset values: all outputs 0; state IDLE; row and write counters 0.

States:
- IDLE: on i_start, latch the row count, clear o_err, go to CLR.
  - Row count 0 → DONE; no row activity.
  - Row count > NUM_ROWS → clamp to NUM_ROWS.
- CLR: o_fl_clr=1 for one cycle; write counter ← 0; go to SM_START.
- SM_START: o_sm_start=1 for one cycle; go to SM_WAIT.
- SM_WAIT: on i_sm_done, go to FL_RUN.
- FL_RUN: o_fl_valid=1. On i_fl_done, go to FL_CHK.
- FL_CHK: o_fl_valid=0.
  - If write counter ≠ 32, set o_err.
  - If last row, go to DONE; otherwise increment the row and go to CLR.
- DONE: o_done=1 for one cycle; go to IDLE.

Write relay:
- Each i_fl_wr_en seen in FL_RUN or FL_CHK gives o_mem_wr_en=1 one cycle later, with address {o_row_idx, i_fl_wr_addr} and data i_fl_wr_data. The write counter increments.
- i_fl_wr_en in any other state: the write is dropped (no o_mem_wr_en) and o_err is set.
- The write counter saturates at 63.
- i_start while busy is ignored.
- i_sm_done outside SM_WAIT is ignored.
- o_err does not abort the job; the job always finishes, except on a watchdog expiry (see Configuration).

## Timing
- Job start: i_start sampled at edge 0 → o_busy and state CLR from edge 1 → o_sm_start high in cycle 2.
- Writer handoff: o_fl_valid rises the cycle after i_sm_done. The writer then issues 32 writes over 33 cycles. i_fl_done rises with the last i_fl_wr_en.
- Row overhead: 4 cycles beyond core latency plus 33 writer cycles. Rows never overlap.
- Write relay latency: exactly 1 cycle.
- Job end: o_done asserts the cycle after FL_CHK of the last row. o_busy drops on the same edge that ends o_done.
- Row index wraps only through the clamp; it never exceeds NUM_ROWS-1.
- i_rst mid-job: all outputs return to 0 immediately and state goes to IDLE. In-flight writer writes are not relayed.

## Configuration
- SOFTMAX_SEQ_TIMEOUT_EN defined: a watchdog counts cycles in SM_WAIT and FL_RUN, resetting on each state entry.
  - At TIMEOUT_CYC it sets o_err, deasserts o_fl_valid, and goes to DONE, skipping the remaining rows.
- SOFTMAX_SEQ_TIMEOUT_EN undefined: no watchdog; SM_WAIT and FL_RUN wait indefinitely, and TIMEOUT_CYC is unused.

## Test plan
- Single row: i_num_rows=1, core done 5 cycles after o_sm_start, writer model with 32 writes.
  - → 32 o_mem_wr_en at addresses 0..31, data matching.
  - → one o_done; o_err=0.
- Full job: i_num_rows=32.
  - → 1024 writes; row 7 element 3 at address 227.
  - → exactly 32 o_fl_clr pulses, each before its o_sm_start; o_done once.
- Short row: writer model asserts done after 31 writes on row 2 of 4.
  - → o_err=1 after FL_CHK of row 2; rows 3 and 4 still run; o_done asserted.
- Boundaries: i_num_rows=0 → o_done 2 cycles after i_start with no o_sm_start. i_num_rows=40 → 32 rows. i_start pulsed during row 1 → ignored.
- Reset mid-job: i_rst asserted in FL_RUN of row 3.
  - → all outputs 0 the same cycle.
  - → a fresh i_start with i_num_rows=1 completes normally.
- Timeout (macro on, TIMEOUT_CYC=20): core never returns i_sm_done.
  - → o_err=1 and o_done about 21 cycles after o_sm_start; no writes.
  - Macro off: o_busy stays high.
